// File: rtl/btn_pkg.sv
// btn_pkg: shared timing constants, widths and hold-phase encoding for the button debouncer
package btn_pkg;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
  localparam int DEBOUNCE_100US = 10000;
  localparam int HOLD_500MS = 50000000;
  localparam int REPEAT_100MS = 10000000;
  localparam int CNT_W = $clog2(DEBOUNCE_100US);
  localparam int HOLD_W = $clog2(max2(HOLD_500MS, REPEAT_100MS));
  typedef enum logic {FIRST = 1'b0, REPEAT = 1'b1} phase_t;
endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button: 2-flop sync, stable-count debounce, press/release pulses, hold auto-repeat
module btn_channel
  import btn_pkg::*;
#(
  parameter int COUNT_SIZE = DEBOUNCE_100US,
  parameter int HOLD_COUNT = HOLD_500MS,
  parameter int REPEAT_COUNT = REPEAT_100MS,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk_100Mhz,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);
  localparam int CW = $clog2(COUNT_SIZE);
  localparam int HW = $clog2(max2(HOLD_COUNT, REPEAT_COUNT));
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_level, r_press, r_release;
  logic w_acc, w_fall;
  assign w_acc = (r_sync[1] != r_level) && (r_cnt == CW'(COUNT_SIZE - 1));
  assign w_fall = w_acc && r_level;
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_in};
      r_cnt <= (r_sync[1] == r_level || w_acc) ? '0 : r_cnt + 1'b1;
      r_level <= r_level ^ w_acc;
      r_press <= w_acc && !r_level;
      r_release <= w_fall;
    end
  assign btn_level = r_level;
  assign btn_press = r_press;
  assign btn_release = r_release;
  generate
    if (REPEAT_EN) begin : g_rep
      logic [HW-1:0] r_hold, w_hold_nxt;
      phase_t r_phase, w_phase_nxt;
      logic r_repeat, w_repeat_nxt, w_term;
      assign w_term = r_hold == ((r_phase == FIRST) ? HW'(HOLD_COUNT - 1) : HW'(REPEAT_COUNT - 1));
      always_ff @(posedge clk_100Mhz or posedge rst)
        if (rst) begin
          r_hold <= '0;
          r_phase <= FIRST;
          r_repeat <= 1'b0;
        end else begin
          r_hold <= w_hold_nxt;
          r_phase <= w_phase_nxt;
          r_repeat <= w_repeat_nxt;
        end
      // a release accepted on the terminal edge suppresses that repeat pulse
      always_comb begin
        w_hold_nxt = !r_level || w_term ? '0 : r_hold + 1'b1;
        w_phase_nxt = !r_level ? FIRST : (w_term ? REPEAT : r_phase);
        w_repeat_nxt = r_level && w_term && !w_fall;
      end
      assign btn_repeat = r_repeat;
    end else begin : g_norep
      assign btn_repeat = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/btn_debouncer_multi.sv
// btn_debouncer_multi: N_BTN independent debounced button channels
module btn_debouncer_multi
  import btn_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int COUNT_SIZE = DEBOUNCE_100US,
  parameter int HOLD_COUNT = HOLD_500MS,
  parameter int REPEAT_COUNT = REPEAT_100MS,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk_100Mhz,
  input  logic rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .COUNT_SIZE(COUNT_SIZE),
      .HOLD_COUNT(HOLD_COUNT),
      .REPEAT_COUNT(REPEAT_COUNT),
      .REPEAT_EN(REPEAT_EN)
    ) u_ch (
      .clk_100Mhz(clk_100Mhz),
      .rst(rst),
      .btn_in(btn_in[i]),
      .btn_level(btn_level[i]),
      .btn_press(btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat(btn_repeat[i])
    );
  end
endmodule

// File: doc/btn_debouncer_multi.md
Name: btn_debouncer_multi

Overview:
Parametrised multi-channel successor to the single-button debouncer for the seven-segment clock front panel. Each channel synchronises a raw push-button and filters bounce with a stable-count window. Each channel outputs a clean level, one-cycle press/release pulses, and an optional hold-to-auto-repeat pulse for fast time-setting. It sits between the board button pins and the clock-setting control FSM.

Parameters:
N_BTN, 4, number of independent button channels (1..16)
COUNT_SIZE, 10000, consecutive stable cycles required to accept a new level (>=2); 100 us at 100 MHz
HOLD_COUNT, 50000000, cycles a press must be held before the first repeat pulse (>=2); 0.5 s
REPEAT_COUNT, 10000000, cycles between subsequent repeat pulses while still held (>=2); 0.1 s
REPEAT_EN, 1, 1 = auto-repeat active; 0 = btn_repeat tied low and hold logic removed

Ports:
clk_100Mhz  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
btn_in  input  N_BTN  raw, asynchronous button pins; bit i = channel i
btn_level  output  N_BTN  debounced level
btn_press  output  N_BTN  one-cycle pulse when the debounced level goes 0->1
btn_release  output  N_BTN  one-cycle pulse when the debounced level goes 1->0
btn_repeat  output  N_BTN  one-cycle auto-repeat pulse while held

Behaviour:
- Clock and reset: one clock, clk_100Mhz. Reset is asynchronous, active-high. All flops clear immediately on rst=1 and release on the first edge after rst=0.
- Reset values: btn_level, btn_press, btn_release, btn_repeat all 0. Synchroniser flops, stable counters and hold counters all 0.
- Synchroniser: 2-flop chain per channel, sync = btn_in delayed 2 edges. No logic reads btn_in directly.
- Debounce counter: per channel, width $clog2(COUNT_SIZE).
  - sync == btn_level: counter <= 0.
  - sync != btn_level and counter < COUNT_SIZE-1: counter <= counter+1.
  - sync != btn_level and counter == COUNT_SIZE-1: btn_level <= sync, counter <= 0.
  - Any single-cycle return to the current level during counting restarts the count from 0. A glitch shorter than COUNT_SIZE cycles never reaches btn_level.
- Latency: a clean raw change sampled at edge k appears on btn_level at edge k+1+COUNT_SIZE (2-stage sync plus COUNT_SIZE counting edges).
- Edge pulses: all outputs are registered.
  - btn_press is high for exactly the one cycle in which btn_level first reads 1.
  - btn_release is high for exactly the one cycle in which btn_level first reads 0.
  - No pulse is generated out of reset, even if a button is held during reset; the level must first be accepted by counting.
- Auto-repeat (REPEAT_EN=1): per channel hold counter, width $clog2(max(HOLD_COUNT,REPEAT_COUNT)).
  - btn_level == 0: hold counter <= 0, phase <= FIRST.
  - btn_level == 1, phase FIRST: count to HOLD_COUNT-1, then pulse btn_repeat, counter <= 0, phase <= REPEAT.
  - phase REPEAT: count to REPEAT_COUNT-1, then pulse btn_repeat, counter <= 0, stay in REPEAT.
  - Hold counting starts on the cycle btn_level becomes 1. The first repeat fires HOLD_COUNT cycles after the btn_press cycle and never coincides with btn_press.
  - Release mid-count aborts silently, with no repeat pulse.
  - The counter never wraps uncontrolled; it resets exactly at its terminal value.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses on the corresponding bits.
- Reset mid-operation: all state aborts, with no pulses on the cycle reset deasserts.

Decomposition:
- Shared package btn_pkg holds:
  - localparams CNT_W = $clog2(COUNT_SIZE) and HOLD_W.
  - Default timing constants for 100 MHz (DEBOUNCE_100US, HOLD_500MS, REPEAT_100MS).
  - The 1-bit phase encoding, FIRST=0 / REPEAT=1.
- Sub-module btn_channel implements one channel: synchroniser, debounce counter, edge detect and hold/repeat logic.
- btn_debouncer_multi is a generate loop of N_BTN btn_channel instances.

Test Plan:
All scenarios use N_BTN=2, COUNT_SIZE=4, HOLD_COUNT=10, REPEAT_COUNT=5, REPEAT_EN=1.
1. Clean press: btn_in[0] 0->1 held -> btn_level[0]=1 and btn_press[0]=1 (single cycle) exactly 5 edges after first sampling. btn_release stays 0 and channel 1 is untouched.
2. Bounce: btn_in[0] toggles 1,0,1,1,0 each cycle, then holds 1 -> no btn_level change until 4 consecutive synced 1s. Exactly one btn_press.
3. Auto-repeat: hold btn_in[0]=1 for 40 cycles after btn_press -> btn_repeat[0] pulses at +10, +15, +20, +25, +30, +35 cycles relative to btn_press.
4. Release mid-hold: release 7 cycles after btn_press -> no btn_repeat. btn_release[0] pulse 5 edges after the raw fall, and the hold counter reads 0 afterwards.
5. Simultaneous: both btn_in bits rise on the same edge -> btn_press = 2'b11 in the same cycle.
6. Async reset: assert rst mid-count and mid-repeat, with no clock edge -> all outputs 0 immediately. Buttons held through reset produce btn_press only after 5 edges post-release.
